// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: pointer/count widths and
// parameter legality, used by both the sync and async FIFOs.
package fifo_pkg;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit params_ok(
      input int data_w,
      input int depth,
      input int af_level,
      input int ae_level
   );
      return (data_w >= 1) && (depth >= 2) &&
             ((depth & (depth - 1)) == 0) &&
             (af_level >= 1) && (af_level <= depth) &&
             (ae_level >= 0) && (ae_level <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array; read port is registered, or combinational
// when SYNC_FIFO_FWFT_EN is defined.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = ptr_w(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we_i) mem_d[waddr_i] = wdata_i;
   end

   // Storage carries no reset; the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

`ifdef SYNC_FIFO_FWFT_EN
   logic unused_rd;
   assign unused_rd = re_i ^ rst_i;
   assign rdata_o   = mem_q[raddr_i];
`else
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   always_comb begin
      rd_data_d = rd_data_q;
      if (re_i) rd_data_d = mem_q[raddr_i];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) rd_data_q <= '0;
      else       rd_data_q <= rd_data_d;
   end

   assign rdata_o = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_prog
   import fifo_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      wr_en_i,
   input  logic [DATA_W-1:0]         wr_data_i,
   input  logic                      rd_en_i,
   input  logic                      err_clr_i,
   output logic [DATA_W-1:0]         rd_data_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic                      almost_full_o,
   output logic                      almost_empty_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      overflow_o,
   output logic                      underflow_o
);

   localparam int AW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
      $error("sync_fifo_prog: illegal parameter set");
   end

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          wr_acc;
   logic          rd_acc;

   assign full_o         = (count_q == CW'(DEPTH));
   assign empty_o        = (count_q == '0);
   assign almost_full_o  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty_o = (count_q <= CW'(AE_LEVEL));
   assign count_o        = count_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = unf_q;

   // A full FIFO still takes a write when a read frees a slot this cycle.
   always_comb begin
      rd_acc   = rd_en_i & ~empty_o;
      wr_acc   = wr_en_i & (~full_o | rd_acc);
      wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      ovf_d = (ovf_q & ~err_clr_i) | (wr_en_i & ~wr_acc);
      unf_d = (unf_q & ~err_clr_i) | (rd_en_i & ~rd_acc);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (wr_acc & ~rst_i),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data_i),
      .re_i    (rd_acc & ~rst_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data_o)
   );

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed and model-checked bench for sync_fifo_prog (standard read mode).
module tb_sync_fifo_prog;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       wr_en_i;
   logic [7:0] wr_data_i;
   logic       rd_en_i;
   logic       err_clr_i;
   logic [7:0] rd_data_o;
   logic       full_o;
   logic       empty_o;
   logic       almost_full_o;
   logic       almost_empty_o;
   logic [4:0] count_o;
   logic       overflow_o;
   logic       underflow_o;

   int n_chk = 0;
   int n_err = 0;

   sync_fifo_prog #(
      .DATA_W   (8),
      .DEPTH    (16),
      .AF_LEVEL (12),
      .AE_LEVEL (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .wr_en_i        (wr_en_i),
      .wr_data_i      (wr_data_i),
      .rd_en_i        (rd_en_i),
      .err_clr_i      (err_clr_i),
      .rd_data_o      (rd_data_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o),
      .count_o        (count_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic we, input logic re, input logic clr,
                       input logic [7:0] d);
      wr_en_i   = we;
      rd_en_i   = re;
      err_clr_i = clr;
      wr_data_i = d;
      @(posedge clk_i);
      #1;
      wr_en_i   = 1'b0;
      rd_en_i   = 1'b0;
      err_clr_i = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"}, 32'(count_o), 0);
      chk({tag, "_empty"}, 32'(empty_o), 1);
      chk({tag, "_ae"}, 32'(almost_empty_o), 1);
      chk({tag, "_full"}, 32'(full_o), 0);
      chk({tag, "_af"}, 32'(almost_full_o), 0);
      chk({tag, "_ovf"}, 32'(overflow_o), 0);
      chk({tag, "_unf"}, 32'(underflow_o), 0);
      chk({tag, "_rdata"}, 32'(rd_data_o), 0);
   endtask

   logic [7:0] q[$];
   logic [7:0] last;
   logic       e_ovf, e_unf;

   initial begin
      rst_i = 1'b1;
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      err_clr_i = 1'b0;
      wr_data_i = '0;
      step(0, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);
      rst_i = 1'b0;
      chk_reset_state("rst");

      // fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 0, 8'(i));
         chk("fill_count", 32'(count_o), 32'(i + 1));
         chk("fill_ae", 32'(almost_empty_o), 32'((i + 1) <= 4));
         chk("fill_af", 32'(almost_full_o), 32'((i + 1) >= 12));
         chk("fill_full", 32'(full_o), 32'((i + 1) == 16));
         chk("fill_ovf", 32'(overflow_o), 0);
      end

      step(1, 0, 0, 8'hEE);
      chk("ovf_set", 32'(overflow_o), 1);
      chk("ovf_count", 32'(count_o), 16);
      step(0, 0, 0, 8'h00);
      chk("ovf_sticky", 32'(overflow_o), 1);
      step(0, 0, 1, 8'h00);
      chk("ovf_clr", 32'(overflow_o), 0);

      for (int i = 0; i < 16; i++) begin
         step(0, 1, 0, 8'h00);
         chk("drain_data", 32'(rd_data_o), 32'(i));
         chk("drain_count", 32'(count_o), 32'(15 - i));
      end
      chk("drain_empty", 32'(empty_o), 1);
      step(0, 1, 0, 8'h00);
      chk("unf_set", 32'(underflow_o), 1);
      chk("unf_hold", 32'(rd_data_o), 32'h0F);
      step(0, 0, 1, 8'h00);
      chk("unf_clr", 32'(underflow_o), 0);

      for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(8'h10 + i));
      chk("refill_full", 32'(full_o), 1);
      step(1, 1, 0, 8'hA5);
      chk("fullsim_count", 32'(count_o), 16);
      chk("fullsim_ovf", 32'(overflow_o), 0);
      chk("fullsim_rdata", 32'(rd_data_o), 32'h10);
      for (int i = 1; i < 16; i++) begin
         step(0, 1, 0, 8'h00);
         chk("fullsim_drain", 32'(rd_data_o), 32'(8'h10 + i));
      end
      step(0, 1, 0, 8'h00);
      chk("fullsim_last", 32'(rd_data_o), 32'hA5);
      chk("fullsim_empty", 32'(empty_o), 1);

      step(1, 1, 0, 8'h33);
      chk("emptysim_count", 32'(count_o), 1);
      chk("emptysim_unf", 32'(underflow_o), 1);
      chk("emptysim_hold", 32'(rd_data_o), 32'hA5);
      step(0, 1, 1, 8'h00);
      chk("emptysim_rd", 32'(rd_data_o), 32'h33);
      chk("emptysim_clr", 32'(underflow_o), 0);

      // random traffic against a queue model
      last  = 8'h33;
      e_ovf = 1'b0;
      e_unf = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         logic we, re, racc, wacc;
         logic [7:0] d;
         we   = ($urandom_range(0, 3) != 0);
         re   = ($urandom_range(0, 3) != 0);
         d    = 8'($urandom_range(0, 255));
         racc = re && (q.size() != 0);
         wacc = we && ((q.size() != 16) || racc);
         if (racc) last = q.pop_front();
         if (wacc) q.push_back(d);
         e_ovf = e_ovf | (we & ~wacc);
         e_unf = e_unf | (re & ~racc);
         step(we, re, 0, d);
         chk("rnd_data", 32'(rd_data_o), 32'(last));
         chk("rnd_count", 32'(count_o), 32'(q.size()));
         chk("rnd_ovf", 32'(overflow_o), 32'(e_ovf));
         chk("rnd_unf", 32'(underflow_o), 32'(e_unf));
      end

      rst_i = 1'b1;
      step(0, 0, 0, 8'h00);
      rst_i = 1'b0;
      for (int i = 0; i < 9; i++) step(1, 0, 0, 8'(8'h40 + i));
      chk("mid_count", 32'(count_o), 9);
      rst_i = 1'b1;
      step(1, 1, 0, 8'h77);
      rst_i = 1'b0;
      chk_reset_state("mid");
      step(1, 0, 0, 8'h5A);
      chk("post_count", 32'(count_o), 1);
      step(0, 1, 0, 8'h00);
      chk("post_data", 32'(rd_data_o), 32'h5A);
      chk("post_empty", 32'(empty_o), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
